// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM states, requester IDs and default sizes for the memory arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    typedef enum logic {FETCH, DATA} req_id_e;

    localparam int N_DEF     = 32;
    localparam int DEPTH_DEF = 256;

endpackage

// File: rtl/mem_arbiter_pick.sv
// mem_arb_pick: chooses the requester granted this cycle (fixed data-first, or round-robin with MEM_ARB_RR_EN)
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic    clk,
    input  logic    rst_n,
    input  logic    grant_i,
`endif
    input  logic    if_req_i,
    input  logic    d_req_i,
    output req_id_e win_o
);

`ifdef MEM_ARB_RR_EN
    req_id_e last_q;

    // Remember who was granted last; reset value FETCH makes the data requester win first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_q <= FETCH;
        else if (grant_i)
            last_q <= win_o;
    end

    assign win_o = (if_req_i && d_req_i) ? ((last_q == DATA) ? FETCH : DATA)
                                         : (d_req_i ? DATA : FETCH);
`else
    assign win_o = d_req_i ? DATA : FETCH;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates fetch and data requesters onto one byte-addressed word memory; MEM_ARB_RR_EN selects round-robin
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         if_req,
    input  logic [N-1:0] if_addr,
    output logic         if_ack,
    output logic [N-1:0] if_rdata,
    input  logic         d_req,
    input  logic         d_we,
    input  logic [N-1:0] d_addr,
    input  logic [N-1:0] d_wdata,
    output logic         d_ack,
    output logic [N-1:0] d_rdata,
    output logic         err,
    output logic [N-1:0] mem_addr,
    output logic         mem_we,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata,
    output logic         busy
);

    state_e       state_q;
    req_id_e      win_q;
    logic         ok_q;
    logic         mem_we_q;
    logic [N-1:0] mem_addr_q;
    logic [N-1:0] mem_wdata_q;
    logic         if_ack_q;
    logic         d_ack_q;
    logic         err_q;
    logic [N-1:0] if_rdata_q;
    logic [N-1:0] d_rdata_q;

    req_id_e      win_d;
    logic         grant_d;
    logic [N-1:0] addr_d;
    logic [N:0]   end_d;
    logic         ok_d;

    assign grant_d = (state_q == IDLE) && (if_req || d_req);
    assign addr_d  = (win_d == DATA) ? d_addr : if_addr;
    // Widened by one bit so a word near the top of the address space cannot wrap into range.
    assign end_d   = {1'b0, addr_d} + (N+1)'(3);
    assign ok_d    = end_d <= (N+1)'(DEPTH - 1);

    mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
        .clk      (clk),
        .rst_n    (rst_n),
        .grant_i  (grant_d),
`endif
        .if_req_i (if_req),
        .d_req_i  (d_req),
        .win_o    (win_d)
    );

    // Transaction FSM: latch the winner in IDLE, drive memory in ACCESS, pulse ack in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            win_q       <= DATA;
            ok_q        <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            mem_we_q <= 1'b0;
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: if (grant_d) begin
                    state_q     <= ACCESS;
                    win_q       <= win_d;
                    ok_q        <= ok_d;
                    mem_addr_q  <= addr_d;
                    mem_wdata_q <= (win_d == DATA) ? d_wdata : '0;
                    mem_we_q    <= (win_d == DATA) && d_we && ok_d;
                end
                ACCESS: begin
                    state_q <= RESP;
                    err_q   <= !ok_q;
                    if (win_q == DATA) begin
                        d_ack_q   <= 1'b1;
                        d_rdata_q <= ok_q ? mem_rdata : '0;
                    end else begin
                        if_ack_q   <= 1'b1;
                        if_rdata_q <= ok_q ? mem_rdata : '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = state_q != IDLE;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign err       = err_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter against a byte-array reference model
module tb_mem_arbiter;
    localparam int N     = 32;
    localparam int DEPTH = 256;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         if_req = 1'b0;
    logic [N-1:0] if_addr = '0;
    logic         if_ack;
    logic [N-1:0] if_rdata;
    logic         d_req = 1'b0;
    logic         d_we = 1'b0;
    logic [N-1:0] d_addr = '0;
    logic [N-1:0] d_wdata = '0;
    logic         d_ack;
    logic [N-1:0] d_rdata;
    logic         err;
    logic [N-1:0] mem_addr;
    logic         mem_we;
    logic [N-1:0] mem_wdata;
    logic [N-1:0] mem_rdata;
    logic         busy;

    always #5 clk = ~clk;

    mem_arbiter #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory model: byte array, falling-edge write, combinational little-endian read.
    logic [7:0] mem [DEPTH];
    logic       clr = 1'b1;
    logic       pre_en = 1'b0;
    int         pre_a = 0;
    logic [7:0] pre_v = '0;

    always @(negedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else if (mem_we) begin
            for (int i = 0; i < 4; i++)
                if (int'(mem_addr[7:0]) + i < DEPTH) mem[int'(mem_addr[7:0]) + i] <= mem_wdata[8*i +: 8];
        end else if (pre_en) begin
            mem[pre_a] <= pre_v;
        end
    end

    always_comb begin
        mem_rdata = '0;
        for (int i = 0; i < 4; i++)
            if (int'(mem_addr[7:0]) + i < DEPTH) mem_rdata[8*i +: 8] = mem[int'(mem_addr[7:0]) + i];
    end

    // Reference model and scoreboard
    typedef struct {
        logic         is_data;
        logic [N-1:0] rdata;
        logic         err;
        logic         chk_rd;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] ref_mem [DEPTH];
    bit         last_data = 1'b0;
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic poke(input int a, input logic [7:0] v);
        ref_mem[a] = v;
        pre_a = a;
        pre_v = v;
        pre_en = 1'b1;
        @(negedge clk);
        #1 pre_en = 1'b0;
    endtask

    task automatic predict(input bit is_data, input bit we, input int a, input logic [N-1:0] wd);
        exp_t e;
        bit   ok;
        ok = a + 3 <= DEPTH - 1;
        if (ok && is_data && we)
            for (int i = 0; i < 4; i++) ref_mem[a + i] = wd[8*i +: 8];
        e.is_data = is_data;
        e.err     = !ok;
        e.chk_rd  = !(is_data && we);
        e.rdata   = '0;
        if (ok)
            for (int i = 0; i < 4; i++) e.rdata[8*i +: 8] = ref_mem[a + i];
        sb.push_back(e);
    endtask

    task automatic wait_ack(input int exp_wait);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(if_ack || d_ack) && n < 8);
        checks++;
        if (!(if_ack || d_ack) || n != exp_wait) begin
            errors++;
            $display("FAIL latency: ack after %0d cycles (seen=%0b) expected %0d", n, if_ack || d_ack, exp_wait);
        end
    endtask

    // Serve n grants from the currently driven requests; drop the winner's req after its ack if asked.
    task automatic txn_loop(input int n, input bit drop);
        for (int k = 0; k < n; k++) begin
            bit wd;
            wd = d_req && !(if_req && RR && last_data);
            last_data = wd;
            predict(wd, wd && d_we, wd ? int'(d_addr[7:0]) : int'(if_addr[7:0]), d_wdata);
            wait_ack(k == 0 ? 2 : 3);
            if (drop) begin
                if (wd) d_req = 1'b0;
                else    if_req = 1'b0;
            end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard on every ack and polices mem_we every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (mem_we && (!busy || if_ack || d_ack || mem_addr > 32'(DEPTH - 4))) begin
                errors++;
                $display("FAIL mem_we: high outside an in-range ACCESS (busy=%0b addr=%h)", busy, mem_addr);
            end
            if (if_ack || d_ack) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack: if_ack=%0b d_ack=%0b with nothing outstanding", if_ack, d_ack);
                end else begin
                    exp_t e;
                    logic [N-1:0] rd;
                    e  = sb.pop_front();
                    rd = e.is_data ? d_rdata : if_rdata;
                    if ((if_ack && d_ack) || d_ack !== e.is_data || err !== e.err || (e.chk_rd && rd !== e.rdata)) begin
                        errors++;
                        $display("FAIL response: if_ack=%0b d_ack=%0b err=%0b rdata=%h expected data=%0b err=%0b rdata=%h",
                                 if_ack, d_ack, err, rd, e.is_data, e.err, e.rdata);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (ref_mem[i]) ref_mem[i] = 8'h00;
        #12;
        chk("reset_acks", {30'd0, if_ack, d_ack}, '0);
        chk("reset_flags", {29'd0, err, busy, mem_we}, '0);
        chk("reset_mem_addr", mem_addr, '0);
        chk("reset_mem_wdata", mem_wdata, '0);
        chk("reset_rdata", if_rdata | d_rdata, '0);
        @(negedge clk);
        clr = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF;
        txn_loop(1, 1'b1);
        d_req = 1'b1; d_we = 1'b0;
        txn_loop(1, 1'b1);
        chk("write_read_model", {ref_mem[16'h13], ref_mem[16'h12], ref_mem[16'h11], ref_mem[16'h10]}, 32'hDEADBEEF);

        poke(32'h20, 8'h78); poke(32'h21, 8'h56); poke(32'h22, 8'h34); poke(32'h23, 8'h12);
        if_req = 1'b1; if_addr = 32'h20;
        txn_loop(1, 1'b1);

        if_req = 1'b1; if_addr = 32'h30; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        txn_loop(4, 1'b0);

        poke(32'hFC, 8'h11); poke(32'hFD, 8'h22); poke(32'hFE, 8'h33); poke(32'hFF, 8'h44);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'hFD; d_wdata = 32'hA5A5A5A5;
        txn_loop(1, 1'b1);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'hFC;
        txn_loop(1, 1'b1);

        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, '0);
        chk("abort_acks", {29'd0, if_ack, d_ack, mem_we}, '0);
        d_req = 1'b0;
        last_data = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_idle", {31'd0, busy}, '0);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        txn_loop(1, 1'b1);

        for (int t = 0; t < 40; t++) begin
            int mode;
            mode    = $urandom_range(0, 2);
            if_addr = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(250, 255)) : 32'($urandom_range(0, 252));
            d_addr  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(250, 255)) : 32'($urandom_range(0, 252));
            d_we    = $urandom_range(0, 1) == 1;
            d_wdata = $urandom;
            if_req  = mode != 1;
            d_req   = mode != 0;
            txn_loop(mode == 2 ? 2 : 1, 1'b1);
        end

        chk("scoreboard_drained", 32'(sb.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
